// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

  localparam int MUL_W     = 32;
  localparam int MUL_CNT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/ready request and done/product response of the multiplier.
interface shift_add_multiplier_if;
  import mul_pkg::*;

  logic                   start;
  logic [MUL_W-1:0]       a;
  logic [MUL_W-1:0]       b;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*MUL_W-1:0]     product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);

endinterface

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder, one full adder per bit.
module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned 32x32->64 multiplier: one multiplier bit per clock through a
// shared ripple-carry adder, 34 cycles from accept to next accept.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W,     // must match the adder; only 32 is legal
  parameter int CNT_W = MUL_CNT_W  // 2**CNT_W must exceed WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_multiplier_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   acc_hi_reg;
  logic [WIDTH-1:0]   mplr_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] step_value;

  assign add_b = mplr_reg[0] ? mcand_reg : '0;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi_reg),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The adder carry is bit 64 of the unshifted partial product, so it lands
  // in acc_hi[31] after the shift rather than being lost.
  assign step_value = {add_cout, add_sum, mplr_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count_reg == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_hi_reg  <= '0;
      mplr_reg    <= '0;
      mcand_reg   <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mcand_reg  <= bus.a;
            mplr_reg   <= bus.b;
            acc_hi_reg <= '0;
            count_reg  <= '0;
          end
        end
        RUN: begin
          acc_hi_reg <= step_value[2*WIDTH-1:WIDTH];
          mplr_reg   <= step_value[WIDTH-1:0];
          count_reg  <= count_reg + 1'b1;
          // Capture on the final step so product only moves on DONE entry.
          if (count_reg == LAST_STEP) product_reg <= step_value;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state_reg == IDLE);
  assign bus.busy    = (state_reg == RUN) || (state_reg == DONE);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed scoreboard bench: the driver queues expected products and accept
// edges, a negedge monitor checks every done pulse against them.
module tb_shift_add_multiplier;
  import mul_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_add_multiplier_if bus ();

  shift_add_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] exp_q[$];
  int          acc_q[$];
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: done must come exactly 32 edges after the accept edge
  // (i.e. during the cycle ending at accept+33) and last one cycle.
  always @(negedge clk) begin
    if (prev_done) begin
      check1("ready_after_done", bus.ready, 1'b1);
      check1("done_one_cycle", bus.done, 1'b0);
    end
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=product %h required=no done (cycle %0d)", bus.product, cyc);
      end else begin
        logic [63:0] e;
        int          s;
        e = exp_q.pop_front();
        s = acc_q.pop_front();
        check64("product", bus.product, e);
        checks++;
        if (cyc - s != 32) begin
          errors++;
          $display("FAIL latency actual=%0d required=32 edges after accept", cyc - s);
        end
        $display("done: product=%h expected=%h latency=%0d", bus.product, e, cyc - s);
      end
    end
    prev_done = bus.done;
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
    int t = 0;
    while (!bus.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check1("accept_ready", bus.ready, 1'b1);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    $display("issue: a=%h b=%h expect=%h", x, y, e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.done && t < 100);
    check1("done_timeout", bus.done, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check1("rst_ready", bus.ready, 1'b1);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check64("rst_product", bus.product, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done();
    repeat (3) @(negedge clk);
    check64("held_idle", bus.product, 64'h0000_0000_0000_000F);

    do_op(32'h0, 32'h1234_5678, 64'h0);
    wait_done();
    do_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_done();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done();

    // start while busy, and in the DONE cycle, must be ignored
    do_op(32'd7, 32'd6, 64'd42);
    repeat (5) begin
      bus.start = 1'b1;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(negedge clk);
      check1("busy_during_run", bus.busy, 1'b1);
      check64("held_during_run", bus.product, 64'hFFFF_FFFE_0000_0001);
    end
    wait_done();
    @(negedge clk);
    bus.start = 1'b0;
    check1("no_accept_from_done", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    check1("still_idle", bus.busy, 1'b0);

    // abort mid-run with reset
    do_op(32'd10, 32'd10, 64'd100);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    check1("abort_ready", bus.ready, 1'b1);
    check1("abort_busy", bus.busy, 1'b0);
    check64("abort_product", bus.product, 64'h0);
    repeat (40) @(negedge clk);
    check1("abort_no_restart", bus.busy, 1'b0);
    do_op(32'd4, 32'd4, 64'd16);
    wait_done();

    // reset wins over a simultaneous start
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    check1("rst_start_ready", bus.ready, 1'b1);
    @(negedge clk);
    check1("rst_start_busy", bus.busy, 1'b0);

    // back-to-back with start held high
    bus.start = 1'b1;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    exp_q.push_back(64'd6);
    acc_q.push_back(cyc + 1);
    $display("issue: a=2 b=3 expect=6 (start held)");
    wait_done();
    bus.a = 32'd5;
    bus.b = 32'd5;
    exp_q.push_back(64'd25);
    acc_q.push_back(cyc + 2);
    $display("issue: a=5 b=5 expect=25 (start held)");
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Iterative unsigned 32x32 -> 64-bit multiplier for the integer datapath, one partial-product bit per clock.
- Feeds the existing 32-bit ripple_carry_adder each cycle (operands: running high accumulator and multiplicand, cin=0) and consumes its sum/cout to form the next partial product.
- Sits beside the ALU in the execute stage. The issue logic starts it with a start/ready handshake and collects the product on a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width. Must equal the adder width; 32 is the only legal value.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  request to multiply; accepted only when ready=1
- a  in  32  multiplicand, sampled in the accept cycle
- b  in  32  multiplier, sampled in the accept cycle
- ready  out  1  1 when in IDLE and able to accept start
- busy  out  1  1 in RUN and DONE
- done  out  1  one-cycle pulse; product valid in that cycle
- product  out  64  unsigned a*b, held stable from done until the next accept

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: rst_n=0 at a rising clk edge forces all state to reset values. No asynchronous path.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0. Internal acc_hi, mplr, mcand and count are all 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - If start=1: latch mcand<=a, mplr<=b, acc_hi<=0, count<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per cycle:
  - Adder input a_add=acc_hi. b_add = mplr[0] ? mcand : 0. cin=0.
  - Next state: {acc_hi, mplr} <= {cout, sum, mplr[31:1]}, i.e. a 65-bit value shifted right by 1. cout must be used, not dropped.
  - count <= count+1. When count==31 at the edge, go to DONE after that step (32 steps total).
- DONE:
  - done=1 for exactly one cycle. product = {acc_hi, mplr}, registered on the DONE entry edge.
  - Next cycle returns to IDLE.
- Latency:
  - start accepted at edge N -> done high during cycle N+33.
  - Earliest next accept is edge N+34 (ready rises in the cycle after done). Throughput is 1 multiply per 34 cycles.
- start while busy=1 is ignored: no latch, no error, current operation unaffected. start in the DONE cycle is also ignored.
- Operands a and b may change freely after the accept edge; only the latched copies are used.
- Product is held after done. It changes only at the DONE entry of the next operation; IDLE, RUN and a new accept leave it untouched.
- Reset mid-RUN: the operation is aborted at that edge. Outputs return to reset values (product=0), and done must not pulse for the aborted operation.
- rst_n and start both active in the same edge: reset wins, the start is dropped.
- Width rule: exactly 64-bit result, no overflow possible. The adder's cout becomes acc_hi[31] for the next step.

Decomposition:
- Shared package mul_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - MUL_W=32, MUL_CNT_W=6
- Sub-module: exactly one instance of the existing ripple_carry_adder (operand add per step). No other sub-modules; control FSM and shift registers live in shift_add_multiplier.

Test Plan:
- a=3, b=5, pulse start -> done exactly 33 cycles after accept edge, product=64'h0000_0000_0000_000F; ready back to 1 next cycle.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (exercises cout every step).
- a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000. Then a=0, b=32'h1234_5678 -> product=0.
- During RUN of a=7, b=6, assert start with a=9, b=9 for several cycles -> ignored, busy stays 1, done once, product=42. Prior product held unchanged until this done.
- Start a=10, b=10, deassert rst_n for one edge at step 15 -> ready=1, busy=0, product=0 next cycle, no done pulse. A fresh start a=4, b=4 then yields product=16.
- Back-to-back: start held high continuously with a=2, b=3, then a=5, b=5 presented after first done -> two accepts 34 cycles apart, products 6 then 25, each done exactly one cycle.
